// File: rtl/axis_pkg.sv
// Shared types and helpers for the buffered AXI4-Stream slave and its FIFO.
package axis_pkg;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_PKT  = 2'd1
  } rx_state_e;

  // Occupancy counters must hold the value DEPTH itself, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Full/empty come from the count; pointers wrap naturally at DEPTH (power of two).
module axis_sync_fifo import axis_pkg::*; #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 16,
  localparam int CNT_W = cnt_width(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != FULL_CNT);
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the count is cleared.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/axis_slave_buffered.sv
// AXI4-Stream slave buffering beats in a FWFT FIFO, with packet tracking and
// optional store-and-forward release of data to the user pop port.
module axis_slave_buffered import axis_pkg::*; #(
  parameter  int DATA_WIDTH  = 8,
  parameter  int DEPTH       = 16,
  parameter  int PACKET_MODE = 0,
  localparam int CNT_W       = cnt_width(DEPTH)
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_arstn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_last,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [CNT_W-1:0]      fifo_count,
  output logic [CNT_W-1:0]      pkt_count,
  output logic                  rx_busy
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic                  init_done_q;
  rx_state_e             rx_state_q, rx_state_d;
  logic [CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [DATA_WIDTH:0]   head;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop;
  logic                  pkt_inc, pkt_dec;

  axis_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (s_axis_aclk),
    .rst_ni  (s_axis_arstn),
    .push_i  (push),
    .wdata_i ({s_axis_tlast, s_axis_tdata}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_cnt)
  );

  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);

  // tready depends only on flops, so data_ready never reaches it combinationally.
  assign s_axis_tready = init_done_q && !fifo_full;
  assign push          = s_axis_tvalid && s_axis_tready;

  // A full buffer releases data even without a complete packet to avoid deadlock.
  assign data_valid = !fifo_empty &&
                      ((PACKET_MODE == 0) || (pkt_cnt_q != '0) || fifo_full);
  assign pop        = data_valid && data_ready;

  assign data_out   = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
  assign data_last  = !fifo_empty && head[DATA_WIDTH];
  assign fifo_count = fifo_cnt;
  assign pkt_count  = pkt_cnt_q;
  assign rx_busy    = (rx_state_q == RX_PKT);

  assign pkt_inc = push && s_axis_tlast;
  assign pkt_dec = pop && data_last;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pkt_inc && !pkt_dec)                          pkt_cnt_d = pkt_cnt_q + 1'b1;
    else if (!pkt_inc && pkt_dec && pkt_cnt_q != '0)  pkt_cnt_d = pkt_cnt_q - 1'b1;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE: if (push && !s_axis_tlast) rx_state_d = RX_PKT;
      RX_PKT:  if (push && s_axis_tlast)  rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      init_done_q <= 1'b0;
      rx_state_q  <= RX_IDLE;
      pkt_cnt_q   <= '0;
    end else begin
      init_done_q <= 1'b1;
      rx_state_q  <= rx_state_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_slave_buffered.sv
// Scoreboard bench for axis_slave_buffered: one cut-through and one
// store-and-forward instance share stimulus; sel picks the one being checked.
module tb_axis_slave_buffered;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          arstn;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, data_ready;
  logic          sel;

  logic          tready_ct, last_ct, valid_ct, busy_ct;
  logic [DW-1:0] dout_ct;
  logic [CW-1:0] cnt_ct, pkt_ct;
  logic          tready_sf, last_sf, valid_sf, busy_sf;
  logic [DW-1:0] dout_sf;
  logic [CW-1:0] cnt_sf, pkt_sf;

  logic          tready_m, last_m, valid_m, busy_m;
  logic [DW-1:0] dout_m;
  logic [CW-1:0] cnt_m, pkt_m;

  logic [DW:0]   exp_q [$];
  int            n_checks = 0;
  int            n_errors = 0;

  always #5 clk = ~clk;

  axis_slave_buffered #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(0)) dut_ct (
    .s_axis_aclk(clk), .s_axis_arstn(arstn), .s_axis_tdata(tdata),
    .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready_ct),
    .data_out(dout_ct), .data_last(last_ct), .data_valid(valid_ct),
    .data_ready(data_ready), .fifo_count(cnt_ct), .pkt_count(pkt_ct),
    .rx_busy(busy_ct)
  );

  axis_slave_buffered #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(1)) dut_sf (
    .s_axis_aclk(clk), .s_axis_arstn(arstn), .s_axis_tdata(tdata),
    .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready_sf),
    .data_out(dout_sf), .data_last(last_sf), .data_valid(valid_sf),
    .data_ready(data_ready), .fifo_count(cnt_sf), .pkt_count(pkt_sf),
    .rx_busy(busy_sf)
  );

  assign tready_m = sel ? tready_sf : tready_ct;
  assign last_m   = sel ? last_sf   : last_ct;
  assign valid_m  = sel ? valid_sf  : valid_ct;
  assign busy_m   = sel ? busy_sf   : busy_ct;
  assign dout_m   = sel ? dout_sf   : dout_ct;
  assign cnt_m    = sel ? cnt_sf    : cnt_ct;
  assign pkt_m    = sel ? pkt_sf    : pkt_ct;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int count_lasts();
    int n;
    n = 0;
    foreach (exp_q[i]) if (exp_q[i][DW]) n++;
    return n;
  endfunction

  // Per-cycle model check, sampled mid-cycle: pops compare against the queue
  // head, then the beat about to be accepted is pushed.
  always @(negedge clk) begin
    if (!arstn) begin
      exp_q.delete();
    end else begin
      logic [DW:0] e;
      int          pk;
      int          sz;
      logic        exp_valid;
      pk = count_lasts();
      sz = exp_q.size();
      exp_valid = (sz != 0) && (!sel || pk != 0 || sz == DEPTH);
      chk("fifo_count", 32'(cnt_m), 32'(sz));
      chk("pkt_count", 32'(pkt_m), 32'(pk));
      chk("data_valid", 32'(valid_m), 32'(exp_valid));
      if (valid_m && data_ready && sz != 0) begin
        e = exp_q.pop_front();
        chk("data_out", 32'(dout_m), 32'(e[DW-1:0]));
        chk("data_last", 32'(last_m), 32'(e[DW]));
      end
      if (tvalid && tready_m) exp_q.push_back({tlast, tdata});
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int   n;
    logic acc;
    n = 0;
    tdata = d; tlast = l; tvalid = 1'b1;
    do begin
      @(negedge clk); acc = tready_m;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    chk("send_accepted", 32'(acc), 32'd1);
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    data_ready = 1'b1;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    tvalid = 1'b0; tlast = 1'b0; tdata = '0; data_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", 32'(tready_m), 32'd0);
    chk("rst_valid", 32'(valid_m), 32'd0);
    chk("rst_dout", 32'(dout_m), 32'd0);
    chk("rst_last", 32'(last_m), 32'd0);
    chk("rst_busy", 32'(busy_m), 32'd0);
    chk("rst_cnt", 32'(cnt_m), 32'd0);
    arstn = 1'b1;
    @(negedge clk);
    chk("tready_first_edge", 32'(tready_m), 32'd0);
    @(negedge clk);
    chk("tready_after_init", 32'(tready_m), 32'd1);
    chk("idle_cnt", 32'(cnt_m), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0;
    do_reset();

    // Cut-through: five-beat packet, user always ready
    data_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      send_beat(DW'(i), i == 5);
      if (i == 1) begin
        chk("ct_latency_valid", 32'(valid_m), 32'd1);
        chk("ct_latency_data", 32'(dout_m), 32'h01);
        chk("rx_busy_mid", 32'(busy_m), 32'd1);
      end
    end
    chk("rx_busy_end", 32'(busy_m), 32'd0);
    drain();
    chk("ct_pkt_zero", 32'(pkt_m), 32'd0);

    // Fill to DEPTH with the user stalled, then hold a 17th beat
    data_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_beat(DW'(8'h10 + i), i == DEPTH - 1);
    chk("full_tready", 32'(tready_m), 32'd0);
    chk("full_count", 32'(cnt_m), 32'd16);
    tdata = 8'h20; tlast = 1'b1; tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("held_count", 32'(cnt_m), 32'd16);
    data_ready = 1'b1;
    @(negedge clk);
    chk("no_comb_tready", 32'(tready_m), 32'd0);
    @(posedge clk); #1;
    data_ready = 1'b0;
    chk("freed_tready", 32'(tready_m), 32'd1);
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
    chk("refill_count", 32'(cnt_m), 32'd16);
    drain();

    // Pushed tlast and popped data_last in the same cycle
    data_ready = 1'b0;
    send_beat(8'h30, 1'b1);
    data_ready = 1'b1;
    send_beat(8'h31, 1'b1);
    chk("simul_pkt", 32'(pkt_m), 32'd1);
    chk("simul_cnt", 32'(cnt_m), 32'd1);
    drain();

    // Reset asserted mid-packet with 7 beats buffered
    data_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_beat(DW'(8'h70 + i), 1'b0);
    chk("mid_cnt", 32'(cnt_m), 32'd7);
    chk("mid_busy", 32'(busy_m), 32'd1);
    arstn = 1'b0;
    #1;
    chk("async_cnt", 32'(cnt_m), 32'd0);
    chk("async_valid", 32'(valid_m), 32'd0);
    chk("async_busy", 32'(busy_m), 32'd0);
    chk("async_tready", 32'(tready_m), 32'd0);
    chk("async_dout", 32'(dout_m), 32'd0);
    do_reset();
    data_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(DW'(8'h40 + i), i == 2);
    drain();
    chk("post_rst_pkt", 32'(pkt_m), 32'd0);

    // Store-and-forward instance
    sel = 1'b1;
    do_reset();
    data_ready = 1'b1;
    send_beat(8'hA0, 1'b0);
    send_beat(8'hA1, 1'b0);
    chk("sf_hold", 32'(valid_m), 32'd0);
    send_beat(8'hA2, 1'b1);
    chk("sf_release", 32'(valid_m), 32'd1);
    chk("sf_head", 32'(dout_m), 32'hA0);
    drain();

    // Packet longer than DEPTH drains through the full override
    for (int i = 0; i < 20; i++) send_beat(DW'(8'h50 + i), i == 19);
    drain();
    chk("long_pkt_zero", 32'(pkt_m), 32'd0);
    chk("long_busy", 32'(busy_m), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
